receiver_uart: RTL and testbench

//  UART 8N1 receiver, receive-side counterpart of emitter_uart. Synchronises async RX line,

---
 rtl/receiver_uart_pkg.sv | 16 +
 rtl/receiver_uart.sv | 146 ++++++++++++++
 tb/tb_receiver_uart.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/receiver_uart_pkg.sv
// Shared definitions for the UART receive path.
// Contents:
//   rx_state_e - receiver FSM state encoding
//   DataBits   - 8N1 data bits per frame
package receiver_uart_pkg;

    localparam int unsigned DataBits = 8;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } rx_state_e;

endpackage

// File: rtl/receiver_uart.sv
// UART 8N1 receiver. Synchronises the async RX line, times bits with a divided-clock down-counter,
// samples mid-bit and presents each received byte as an AXI-stream beat.
// Ports:
//   i_clk       clock, single domain
//   i_rst       synchronous active-high reset
//   i_uart_rx   async serial input, idle high
//   o_tdata     received byte (LSB = first data bit on the line)
//   o_tvalid    byte available
//   i_tready    consumer accepts the byte when o_tvalid & i_tready
//   o_frame_err one-cycle pulse: stop bit sampled low
//   o_overrun   one-cycle pulse: byte completed while the previous beat was still unaccepted
module receiver_uart
    import receiver_uart_pkg::*;
#(
    parameter int unsigned clk_freq_hz = 16000000,
    parameter int unsigned baud_rate   = 57600
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_uart_rx,
    output logic [7:0] o_tdata,
    output logic       o_tvalid,
    input  logic       i_tready,
    output logic       o_frame_err,
    output logic       o_overrun
);

    localparam int unsigned CLKS_PER_BIT = clk_freq_hz / baud_rate;
    localparam int unsigned TimerW = $clog2(CLKS_PER_BIT);
    localparam logic [TimerW-1:0] FullReload = TimerW'(CLKS_PER_BIT - 1);
    localparam logic [TimerW-1:0] HalfReload = TimerW'(CLKS_PER_BIT / 2 - 1);

    logic              rx_meta_q, rx_s_q, rx_prev_q;
    // Marks which synchroniser stages hold real line samples rather than reset values, so a
    // line that is already low at reset release is not mistaken for a start edge.
    logic [2:0]        fill_q;
    rx_state_e         state_q, state_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shift_q, shift_d;
    logic              done_q, done_d;
    logic              ferr_q, ferr_d;
    logic [7:0]        tdata_q, tdata_d;
    logic              tvalid_q, tvalid_d;
    logic              ovr_q, ovr_d;

    logic tick, fall, deliver;

    assign tick = (timer_q == '0);
    assign fall = fill_q[2] & rx_prev_q & ~rx_s_q;

    always_comb begin
        state_d   = state_q;
        timer_d   = tick ? FullReload : timer_q - 1'b1;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        done_d    = 1'b0;
        ferr_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (fall) begin
                    state_d = StStart;
                    timer_d = HalfReload;
                end
            end
            StStart: begin
                if (tick) begin
                    if (rx_s_q) begin
                        state_d = StIdle;
                    end else begin
                        state_d   = StData;
                        bit_idx_d = '0;
                    end
                end
            end
            StData: begin
                if (tick) begin
                    shift_d = {rx_s_q, shift_q[7:1]};
                    if (bit_idx_q == 3'(DataBits - 1)) begin
                        state_d = StStop;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
            StStop: begin
                if (tick) begin
                    state_d = StIdle;
                    done_d  = rx_s_q;
                    ferr_d  = ~rx_s_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Delivery happens the cycle after the stop sample; an accept in that same cycle frees the slot.
    always_comb begin
        deliver  = done_q & (~tvalid_q | i_tready);
        tvalid_d = tvalid_q & ~i_tready;
        tdata_d  = tdata_q;
        if (deliver) begin
            tvalid_d = 1'b1;
            tdata_d  = shift_q;
        end
        ovr_d = done_q & ~deliver;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
            fill_q    <= '0;
            state_q   <= StIdle;
            timer_q   <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            done_q    <= 1'b0;
            ferr_q    <= 1'b0;
            tdata_q   <= '0;
            tvalid_q  <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            rx_meta_q <= i_uart_rx;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
            fill_q    <= {fill_q[1:0], 1'b1};
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            done_q    <= done_d;
            ferr_q    <= ferr_d;
            tdata_q   <= tdata_d;
            tvalid_q  <= tvalid_d;
            ovr_q     <= ovr_d;
        end
    end

    assign o_tdata     = tdata_q;
    assign o_tvalid    = tvalid_q;
    assign o_frame_err = ferr_q;
    assign o_overrun   = ovr_q;

endmodule

// File: tb/tb_receiver_uart.sv
// Scoreboard bench for receiver_uart at 8 clocks per bit.
module tb_receiver_uart;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tready;
    logic       frame_err;
    logic       overrun;

    int n_checks = 0;
    int n_fail   = 0;
    int ferr_cnt = 0;
    int ovr_cnt  = 0;
    int exp_ferr = 0;
    int exp_ovr  = 0;

    logic [7:0] exp_q[$];

    logic       prev_vld  = 1'b0;
    logic       prev_rdy  = 1'b0;
    logic [7:0] prev_data = 8'h00;

    receiver_uart #(
        .clk_freq_hz(8),
        .baud_rate  (1)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_uart_rx  (rx),
        .o_tdata    (tdata),
        .o_tvalid   (tvalid),
        .i_tready   (tready),
        .o_frame_err(frame_err),
        .o_overrun  (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: pops the scoreboard on every accepted beat and checks handshake rules.
    always @(negedge clk) begin
        if (rst) begin
            prev_vld <= 1'b0;
            prev_rdy <= 1'b0;
        end else begin
            if (tvalid && tready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL beat_unexpected: got %02h, expected no beat", tdata);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (tdata !== e) begin
                        n_fail++;
                        $display("FAIL beat_data: got %02h, expected %02h", tdata, e);
                    end
                end
            end
            if (prev_vld && !prev_rdy) begin
                n_checks++;
                if (!tvalid || tdata !== prev_data) begin
                    n_fail++;
                    $display("FAIL beat_stable: got vld=%0b data=%02h, expected vld=1 data=%02h",
                             tvalid, tdata, prev_data);
                end
            end
            if (prev_vld && prev_rdy) begin
                n_checks++;
                if (tvalid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL tvalid_drop: got tvalid=%0b after accept, expected 0", tvalid);
                end
            end
            if (frame_err) ferr_cnt++;
            if (overrun) ovr_cnt++;
            if (frame_err || overrun) begin
                n_checks++;
                if (frame_err && overrun) begin
                    n_fail++;
                    $display("FAIL err_exclusive: got frame_err=1 overrun=1, expected at most one");
                end
            end
            prev_vld  <= tvalid;
            prev_rdy  <= tready;
            prev_data <= tdata;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        idle(8);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            idle(8);
        end
        rx = stop_bit;
        idle(8);
    endtask

    task automatic drain(input string name);
        int cyc;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 400) begin
            idle(1);
            cyc++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_timeout: got %0d beats outstanding, expected 0", name, exp_q.size());
        end
        idle(20);
    endtask

    task automatic check_errs(input string name);
        n_checks++;
        if (ferr_cnt != exp_ferr) begin
            n_fail++;
            $display("FAIL %s_frame_err: got %0d pulse cycles, expected %0d", name, ferr_cnt, exp_ferr);
        end
        n_checks++;
        if (ovr_cnt != exp_ovr) begin
            n_fail++;
            $display("FAIL %s_overrun: got %0d pulse cycles, expected %0d", name, ovr_cnt, exp_ovr);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0b, expected %0b", name, got, want);
        end
    endtask

    initial begin
        rst    = 1'b1;
        rx     = 1'b1;
        tready = 1'b1;
        idle(4);
        @(negedge clk);
        check_bit("rst_tvalid", tvalid, 1'b0);
        check_bit("rst_frame_err", frame_err, 1'b0);
        check_bit("rst_overrun", overrun, 1'b0);
        n_checks++;
        if (tdata !== 8'h00) begin
            n_fail++;
            $display("FAIL rst_tdata: got %02h, expected 00", tdata);
        end
        idle(1);
        rst = 1'b0;
        idle(16);

        // 1: single byte
        exp_q.push_back(8'h55);
        send_byte(8'h55, 1'b1);
        idle(8);
        drain("t1");
        check_errs("t1");

        // 2: back-to-back
        exp_q.push_back(8'hA3);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        send_byte(8'hA3, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        idle(8);
        drain("t2");
        check_errs("t2");

        // 3: short low glitch, then a good byte
        rx = 1'b0;
        idle(3);
        rx = 1'b1;
        idle(30);
        exp_q.push_back(8'h3C);
        send_byte(8'h3C, 1'b1);
        idle(8);
        drain("t3");
        check_errs("t3");

        // 4: stop bit low, then recovery
        exp_ferr++;
        send_byte(8'h81, 1'b0);
        rx = 1'b1;
        idle(16);
        check_errs("t4a");
        exp_q.push_back(8'h42);
        send_byte(8'h42, 1'b1);
        idle(8);
        drain("t4");
        check_errs("t4");

        // 5: consumer stalled, second byte overruns
        tready = 1'b0;
        exp_q.push_back(8'h11);
        exp_ovr++;
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        idle(20);
        check_bit("t5_held_valid", tvalid, 1'b1);
        n_checks++;
        if (tdata !== 8'h11) begin
            n_fail++;
            $display("FAIL t5_held_data: got %02h, expected 11", tdata);
        end
        tready = 1'b1;
        drain("t5");
        idle(40);
        check_errs("t5");

        // 6: reset mid-frame with the line left low afterwards
        rx = 1'b0;
        idle(8);
        rx = 1'b1;
        idle(8);
        rx = 1'b0;
        idle(4);
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(2);
        check_bit("t6_tvalid_after_rst", tvalid, 1'b0);
        idle(40);
        rx = 1'b1;
        idle(16);
        check_errs("t6a");
        exp_q.push_back(8'h5A);
        send_byte(8'h5A, 1'b1);
        idle(8);
        drain("t6");
        check_errs("t6");

        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL final_queue: got %0d beats outstanding, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
